// File: rtl/mov_sequencer.sv
// Sequences LDW/STW/MV instructions over one register-file read port, a req/ack memory port and the write-back port.
// Latency from accept (cycle 0): MV imm 1, MV reg 2, illegal opcode 1; LDW/STW finish one cycle after the mem_ack cycle.
// Backpressure: instr_ready is high only in IDLE; the memory side stalls the sequencer in MEM until mem_ack.
//
// Ports: instruction in (instr_valid/instr_ready, opcode, has_imm, imm, rs_idx, rd_idx),
//        register file (rf_raddr/rf_rdata read, rf_we/rf_waddr/rf_wdata write),
//        memory (mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in),
//        status (done pulse, err qualifying done).
// Optional feature: define MOV_TIMEOUT_EN to abandon a MEM wait after TIMEOUT_CYCLES cycles with err.
module mov_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  opcode,
  input  logic        has_imm,
  input  logic [15:0] imm,
  input  logic [4:0]  rs_idx,
  input  logic [4:0]  rd_idx,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] OP_LDW = 5'b00001;
  localparam logic [4:0] OP_STW = 5'b00010;
  localparam logic [4:0] OP_MV  = 5'b00011;

  typedef enum logic [2:0] {IDLE, SRC, DATA, MEM, WB} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic [4:0]  opcode_q;
  logic [4:0]  rd_q;
  logic [31:0] src_q;    // resolved source: immediate or reg[rs_idx]; also the memory address
  logic [31:0] wdata_q;  // store data read from reg[rd_idx]

`ifdef MOV_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;
`endif

  // Address/data registers are only meaningful while mem_req is high.
  assign mem_addr  = src_q;
  assign mem_wdata = wdata_q;
  assign rf_waddr  = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      opcode_q    <= '0;
      rd_q        <= '0;
      src_q       <= '0;
      wdata_q     <= '0;
      rf_raddr    <= '0;
      rf_we       <= 1'b0;
      rf_wdata    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef MOV_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // Pulse-style outputs default low; the state that owns them re-asserts.
      done     <= 1'b0;
      err      <= 1'b0;
      rf_we    <= 1'b0;
      rf_raddr <= '0;
`ifdef MOV_TIMEOUT_EN
      if (state != MEM) tmo_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_ready <= 1'b0;
            opcode_q    <= opcode;
            rd_q        <= rd_idx;
            if (has_imm) src_q <= {16'b0, imm};
            if (!(opcode == OP_LDW || opcode == OP_STW || opcode == OP_MV)) begin
              state <= WB;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!has_imm) begin
              state    <= SRC;
              rf_raddr <= rs_idx;
            end else if (opcode == OP_STW) begin
              state    <= DATA;
              rf_raddr <= rd_idx;
            end else if (opcode == OP_LDW) begin
              state   <= MEM;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end else begin
              // MV with immediate completes straight away.
              state    <= WB;
              done     <= 1'b1;
              rf_we    <= 1'b1;
              rf_wdata <= {16'b0, imm};
            end
          end
        end
        SRC: begin
          src_q <= rf_rdata;
          if (opcode_q == OP_STW) begin
            state    <= DATA;
            rf_raddr <= rd_q;
          end else if (opcode_q == OP_LDW) begin
            state   <= MEM;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end else begin
            state    <= WB;
            done     <= 1'b1;
            rf_we    <= 1'b1;
            rf_wdata <= rf_rdata;
          end
        end
        DATA: begin
          // Only STW passes through here.
          wdata_q <= rf_rdata;
          state   <= MEM;
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
        end
        MEM: begin
          // An ack arriving on the expiry cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WB;
            done    <= 1'b1;
            if (opcode_q == OP_LDW) begin
              rf_we    <= 1'b1;
              rf_wdata <= mem_rdata;
            end
          end
`ifdef MOV_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WB;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          // done/rf_we were raised on entry and drop here; no accept this cycle.
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mov_sequencer.sv
// Testbench for mov_sequencer: register file and memory are modelled here; expected results
// come from an instruction-level model (source resolution, completion cycle, write-back value).
module tb_mov_sequencer;

  localparam int TMO = 4;
  localparam logic [4:0] LDW = 5'd1;
  localparam logic [4:0] STW = 5'd2;
  localparam logic [4:0] MV  = 5'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  opcode;
  logic        has_imm;
  logic [15:0] imm;
  logic [4:0]  rs_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;

  logic [31:0] regs [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign rf_rdata = regs[rf_raddr];

  mov_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .has_imm(has_imm), .imm(imm), .rs_idx(rs_idx), .rd_idx(rd_idx),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; has_imm = 1'b0; imm = '0;
    rs_idx = '0; rd_idx = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    repeat (2) @(negedge clk);
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    tests++; if ({mem_req, mem_we, rf_we, done, err} !== 5'b0) begin fails++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, rf_we, done, err}); end
    tests++; if ({rf_raddr, rf_waddr} !== 10'b0) begin fails++;
      $display("FAIL reset_addr got=%h exp=0", {rf_raddr, rf_waddr}); end
    tests++; if ({mem_addr, mem_wdata, rf_wdata} !== 96'b0) begin fails++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, rf_wdata}); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Issue one instruction and follow it to done. ack_dly: MEM cycle (1-based) that carries
  // mem_ack; 0 = never acknowledge.
  task automatic run_instr(input string tag, input logic [4:0] op, input logic hi,
                           input logic [15:0] im, input logic [4:0] rs, input logic [4:0] rd,
                           input int ack_dly);
    logic legal, is_mem, tmo, exp_err, exp_we, got_done;
    logic raddr_bad, mem_bad, rdy_bad, idle_bad, req_in_done;
    logic [31:0] src, sdat, ld, exp_wdata, got_wdata;
    logic [4:0] exp_raddr, got_waddr;
    logic got_err, got_we;
    int pre, eff, exp_done, cyc, memcyc, exp_memcyc;
    legal  = (op == LDW) || (op == STW) || (op == MV);
    is_mem = legal && (op == LDW || op == STW);
    src    = hi ? {16'h0, im} : regs[rs];
    sdat   = regs[rd];
    ld     = $urandom;
    pre    = (hi ? 0 : 1) + ((op == STW) ? 1 : 0);
    tmo    = 1'b0;
    eff    = ack_dly;
`ifdef MOV_TIMEOUT_EN
    if (is_mem && (ack_dly == 0 || ack_dly > TMO)) begin tmo = 1'b1; eff = TMO; end
`endif
    exp_done   = legal ? pre + (is_mem ? eff : 0) + 1 : 1;
    exp_err    = !legal || tmo;
    exp_we     = legal && !tmo && (op == LDW || op == MV);
    exp_wdata  = (op == LDW) ? ld : src;
    exp_memcyc = is_mem ? eff : 0;

    @(negedge clk);
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL %s ready_idle got=%b exp=1", tag, instr_ready); end
    instr_valid = 1'b1; opcode = op; has_imm = hi; imm = im; rs_idx = rs; rd_idx = rd;
    @(posedge clk);
    cyc = 0; memcyc = 0; got_done = 0;
    raddr_bad = 0; mem_bad = 0; rdy_bad = 0; idle_bad = 0; req_in_done = 0;
    got_err = 0; got_we = 0; got_waddr = '0; got_wdata = '0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      // Busy-time instruction inputs are garbage and must be ignored.
      instr_valid = 1'($urandom_range(0, 1)); opcode = 5'($urandom); has_imm = 1'($urandom);
      imm = 16'($urandom); rs_idx = 5'($urandom); rd_idx = 5'($urandom);
      mem_ack = 1'b0;
      exp_raddr = (legal && !hi && cyc == 1) ? rs : (legal && op == STW && cyc == pre) ? rd : 5'd0;
      if (rf_raddr !== exp_raddr) raddr_bad = 1;
      if (instr_ready !== 1'b0) rdy_bad = 1;
      if (done === 1'b1) begin
        got_done = 1; got_err = err; got_we = rf_we; got_waddr = rf_waddr; got_wdata = rf_wdata;
        req_in_done = mem_req;
      end else begin
        if (rf_we !== 1'b0 || err !== 1'b0) idle_bad = 1;
        if (mem_req === 1'b1) begin
          memcyc++;
          if (mem_addr !== src || mem_we !== (op == STW) || (op == STW && mem_wdata !== sdat)) mem_bad = 1;
          if (memcyc == ack_dly) begin mem_ack = 1'b1; mem_rdata = ld; end
          else mem_rdata = $urandom;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1; mem_rdata = $urandom;  // stray ack outside MEM
        end
      end
    end
    mem_ack = 1'b0; instr_valid = 1'b0;
    tests++; if (!got_done || cyc != exp_done) begin fails++;
      $display("FAIL %s done_cycle got=%0d(done=%0d) exp=%0d", tag, cyc, got_done, exp_done); end
    tests++; if (got_err !== exp_err) begin fails++; $display("FAIL %s err got=%b exp=%b", tag, got_err, exp_err); end
    tests++; if (got_we !== exp_we) begin fails++; $display("FAIL %s rf_we got=%b exp=%b", tag, got_we, exp_we); end
    if (exp_we) begin
      tests++; if (got_waddr !== rd || got_wdata !== exp_wdata) begin fails++;
        $display("FAIL %s writeback got=r%0d=%h exp=r%0d=%h", tag, got_waddr, got_wdata, rd, exp_wdata); end
    end
    tests++; if (memcyc != exp_memcyc || mem_bad || req_in_done) begin fails++;
      $display("FAIL %s mem got=cycles %0d bad %b req_in_done %b exp=cycles %0d", tag, memcyc, mem_bad, req_in_done, exp_memcyc); end
    tests++; if (raddr_bad || rdy_bad || idle_bad) begin fails++;
      $display("FAIL %s side got=raddr_bad %b rdy_bad %b early_we_err %b exp=000", tag, raddr_bad, rdy_bad, idle_bad); end
    if (exp_we) regs[rd] = exp_wdata;
  endtask

  task automatic test_directed();
    regs[5] = 32'h12345678; regs[2] = 32'h100; regs[4] = 32'hCAFE;
    run_instr("mv_imm",  MV,  1'b1, 16'hBEEF, 5'd0, 5'd3, 0);
    run_instr("mv_reg",  MV,  1'b0, 16'h0,    5'd5, 5'd7, 0);
    run_instr("stw_reg", STW, 1'b0, 16'h0,    5'd2, 5'd4, 3);
    run_instr("ldw_imm", LDW, 1'b1, 16'h0040, 5'd0, 5'd9, 1);
    run_instr("illegal", 5'b11111, 1'b0, 16'h0, 5'd1, 5'd2, 1);
    run_instr("ldw_reg", LDW, 1'b0, 16'h0,    5'd2, 5'd2, 2);
    run_instr("stw_imm", STW, 1'b1, 16'h1234, 5'd0, 5'd3, 1);
    tests++; if (regs[3] !== 32'h0000BEEF || regs[7] !== 32'h12345678) begin fails++;
      $display("FAIL directed_model got=%h/%h exp=0000beef/12345678", regs[3], regs[7]); end
  endtask

  task automatic test_timeout();
`ifdef MOV_TIMEOUT_EN
    run_instr("tmo_never", LDW, 1'b1, 16'h0080, 5'd0, 5'd6, 0);
    run_instr("tmo_edge",  LDW, 1'b1, 16'h0084, 5'd0, 5'd6, TMO);
    run_instr("tmo_stw",   STW, 1'b0, 16'h0,    5'd1, 5'd2, TMO + 3);
`else
    run_instr("long_wait", LDW, 1'b1, 16'h0080, 5'd0, 5'd6, 30);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      int r, dly;
      r = $urandom_range(0, 9);
      if (r == 0) op = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(4, 31));
      else op = 5'(1 + r % 3);
`ifdef MOV_TIMEOUT_EN
      dly = $urandom_range(0, 7);
`else
      dly = $urandom_range(1, 7);
`endif
      run_instr($sformatf("rand%0d", n), op, 1'($urandom), 16'($urandom),
                5'($urandom), 5'($urandom), dly);
    end
  endtask

  // instr_valid held high: WB never accepts, so completions come every other cycle.
  task automatic test_back_to_back();
    int done_bad, rdy_bad, wd_bad;
    logic [15:0] im;
    logic [4:0] rd;
    im = 16'($urandom); rd = 5'($urandom_range(1, 31));
    done_bad = 0; rdy_bad = 0; wd_bad = 0;
    @(negedge clk);
    instr_valid = 1'b1; opcode = MV; has_imm = 1'b1; imm = im; rs_idx = 5'd0; rd_idx = rd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done !== (c % 2 == 1) || rf_we !== (c % 2 == 1)) done_bad++;
      if (instr_ready !== (c % 2 == 0)) rdy_bad++;
      if (c % 2 == 1 && (rf_wdata !== {16'h0, im} || rf_waddr !== rd)) wd_bad++;
    end
    instr_valid = 1'b0;
    regs[rd] = {16'h0, im};
    tests++; if (done_bad != 0) begin fails++; $display("FAIL b2b_done got=%0d bad cycles exp=0", done_bad); end
    tests++; if (rdy_bad != 0) begin fails++; $display("FAIL b2b_ready got=%0d bad cycles exp=0", rdy_bad); end
    tests++; if (wd_bad != 0) begin fails++; $display("FAIL b2b_wdata got=%0d bad cycles exp=0", wd_bad); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int bad;
    @(negedge clk);
    instr_valid = 1'b1; opcode = LDW; has_imm = 1'b1; imm = 16'h0040; rs_idx = 5'd0; rd_idx = 5'd11;
    @(posedge clk);
    @(negedge clk) instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || rf_we !== 1'b0 || instr_ready !== 1'b1) begin fails++;
      $display("FAIL rst_async got=req %b we %b rdy %b exp=req 0 we 0 rdy 1", mem_req, rf_we, instr_ready); end
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done !== 1'b0 || rf_we !== 1'b0 || mem_req !== 1'b0 || instr_ready !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rst_late_ack got=%0d bad cycles exp=0", bad); end
    run_instr("post_reset", MV, 1'b1, 16'h5A5A, 5'd0, 5'd12, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
